// File: rtl/toggle_decoder.sv
// Recovers toggle events from a remote T-flip-flop encoder line.
// Ports: clk, reset (sync, active-high), in_Q (async toggle line),
//        pulse_out (1-cycle event pulse), evt_valid/evt_ready (event drain),
//        pend_count, total_count, overflow (sticky), busy_init.
module toggle_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8,
    parameter int PEND_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_Q,
    output logic                  pulse_out,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [PEND_WIDTH-1:0] pend_count,
    output logic [CNT_WIDTH-1:0]  total_count,
    output logic                  overflow,
    output logic                  busy_init
);

    localparam int IW = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(SYNC_STAGES);
    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          init_cnt;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic                   prev;
    logic                   det;
    logic                   acc;

    assign sync_q    = sync_r[SYNC_STAGES-1];
    assign evt_valid = (pend_count != '0);
    assign acc       = evt_valid && evt_ready;
    // Only RUN compares against prev; INIT absorbs the level seen at release.
    assign det       = (state == RUN) && (sync_q ^ prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_init = 1'b0;
        case (state)
            INIT: begin
                busy_init = 1'b1;
                if (init_cnt == INIT_LAST) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt <= '0;
            sync_r   <= '0;
            prev     <= 1'b0;
        end else begin
            if (state == INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_Q};
            prev   <= sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pulse_out   <= 1'b0;
            pend_count  <= '0;
            total_count <= '0;
            overflow    <= 1'b0;
        end else begin
            pulse_out <= det;
            if (det) begin
                total_count <= total_count + 1'b1;
            end
            // A simultaneous detect and accept cancels out, even when full.
            case ({det, acc})
                2'b10: begin
                    if (pend_count == PEND_MAX) begin
                        overflow <= 1'b1;
                    end else begin
                        pend_count <= pend_count + 1'b1;
                    end
                end
                2'b01: begin
                    pend_count <= pend_count - 1'b1;
                end
                default: begin
                    pend_count <= pend_count;
                end
            endcase
        end
    end

endmodule
